// File: rtl/ram_burst_pkg.sv
// Shared state encodings and command constants for the burst RAM engine.
package ram_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_OUT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port RAM: synchronous write, registered read. The array is never reset;
// only the read register clears so the read port starts at a known value.
module ram_sp_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst access engine over a single-port synchronous RAM: one command, then a
// write or read stream over valid/ready with wrapping address.
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2**ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              last;
    logic              mem_we;
    logic              mem_re;

    assign last   = (remaining == LEN_W'(1));
    assign mem_we = (state == ST_WR) && wr_valid;
    assign mem_re = (state == ST_RD_REQ);

    ram_sp_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr),
        .wdata (wr_data),
        .rdata (rd_data)
    );

    // Handshake outputs are registered and updated together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= (cmd_len == '0) ? LEN_W'(DEPTH) : cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_rw == RW_READ) begin
                            state <= ST_RD_REQ;
                        end else begin
                            state    <= ST_WR;
                            wr_ready <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_valid) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (last) begin
                            state    <= ST_DONE;
                            wr_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_RD_REQ: begin
                    state    <= ST_RD_OUT;
                    rd_valid <= 1'b1;
                end
                ST_RD_OUT: begin
                    if (rd_ready) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        rd_valid  <= 1'b0;
                        if (last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    wr_ready  <= 1'b0;
                    rd_valid  <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: a table of burst commands plus hand-written
// sequences for stall, reset-abort and ignored-input corner cases.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       busy;
    logic       done;

    ram_burst_ctrl #(
        .DATA_W (8),
        .ADDR_W (4),
        .LEN_W  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rw;
        logic [3:0]       addr;
        logic [4:0]       len;
        logic [15:0][7:0] data;
        int               stall_idx;
        int               stall;
    } vec_t;

    vec_t vecs[8];
    int   nvec = 0;
    int   nerr = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [4:0] len,
                            input logic [15:0][7:0] d, input int inj);
        int n;
        int d0;
        int b0;
        n = (len == 5'd0) ? 16 : int'(len);
        @(negedge clk);
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 1);
        d0 = done_cnt;
        b0 = busy_cnt;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = a; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("wr_ready", {31'd0, wr_ready}, 1);
            if (i == inj) begin
                chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
                cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 4'd7; cmd_len = 5'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            wr_valid = 1'b1;
            wr_data  = d[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        chk("wr_done_hi", {31'd0, done}, 1);
        chk("wr_ready_done", {31'd0, wr_ready}, 0);
        @(negedge clk);
        #1;
        chk("wr_done_lo", {31'd0, done}, 0);
        chk("wr_idle_ready", {31'd0, cmd_ready}, 1);
        chk("wr_idle_busy", {31'd0, busy}, 0);
        chk("wr_done_count", done_cnt - d0, 1);
        chk("wr_busy_cycles", busy_cnt - b0, n + 1);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [4:0] len,
                           input logic [15:0][7:0] e, input int stall_idx, input int stall);
        int n;
        int d0;
        int w;
        n = (len == 5'd0) ? 16 : int'(len);
        @(negedge clk);
        chk("rd_cmd_ready", {31'd0, cmd_ready}, 1);
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = a; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rd_valid_early", {31'd0, rd_valid}, 0);
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (rd_valid !== 1'b1 && w < 8);
            chk("rd_valid_latency", w, 1);
            chk("rd_data", {24'd0, rd_data}, {24'd0, e[i]});
            if (i == stall_idx) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("stall_valid", {31'd0, rd_valid}, 1);
                    chk("stall_data", {24'd0, rd_data}, {24'd0, e[i]});
                end
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            chk("rd_valid_drop", {31'd0, rd_valid}, 0);
        end
        chk("rd_done_hi", {31'd0, done}, 1);
        @(negedge clk);
        #1;
        chk("rd_done_lo", {31'd0, done}, 0);
        chk("rd_idle_ready", {31'd0, cmd_ready}, 1);
        chk("rd_idle_busy", {31'd0, busy}, 0);
        chk("rd_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0][7:0] d;
        int d0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;

        for (int k = 0; k < 8; k++) begin
            vecs[k].data = '0; vecs[k].stall_idx = -1; vecs[k].stall = 0;
        end
        for (int i = 0; i < 16; i++) vecs[0].data[i] = 8'(i * i);
        vecs[0].rw = 1'b0; vecs[0].addr = 4'd0;  vecs[0].len = 5'd16;
        vecs[1] = vecs[0]; vecs[1].rw = 1'b1;
        vecs[2].rw = 1'b0; vecs[2].addr = 4'd14; vecs[2].len = 5'd4;
        vecs[2].data[0] = 8'hA0; vecs[2].data[1] = 8'hA1;
        vecs[2].data[2] = 8'hA2; vecs[2].data[3] = 8'hA3;
        vecs[3].rw = 1'b1; vecs[3].addr = 4'd0;  vecs[3].len = 5'd2;
        vecs[3].data[0] = 8'hA2; vecs[3].data[1] = 8'hA3;
        vecs[4].rw = 1'b1; vecs[4].addr = 4'd14; vecs[4].len = 5'd2;
        vecs[4].data[0] = 8'hA0; vecs[4].data[1] = 8'hA1;
        vecs[5].rw = 1'b1; vecs[5].addr = 4'd2;  vecs[5].len = 5'd3;
        vecs[5].data[0] = 8'd4; vecs[5].data[1] = 8'd9; vecs[5].data[2] = 8'd16;
        vecs[5].stall_idx = 1; vecs[5].stall = 3;
        for (int i = 0; i < 16; i++) vecs[6].data[i] = 8'h55;
        vecs[6].rw = 1'b0; vecs[6].addr = 4'd5;  vecs[6].len = 5'd0;
        vecs[7] = vecs[6]; vecs[7].rw = 1'b1; vecs[7].addr = 4'd9;

        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].rw)
                do_read(vecs[k].addr, vecs[k].len, vecs[k].data, vecs[k].stall_idx, vecs[k].stall);
            else
                do_write(vecs[k].addr, vecs[k].len, vecs[k].data, -1);
        end

        // Reset two words into an eight-word write burst.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 4'd8; cmd_len = 5'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("abort_wr_ready", {31'd0, wr_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        d = '0; d[0] = 8'hC0; d[1] = 8'hC1;
        do_read(4'd8, 5'd2, d, -1, 0);
        d = '0; d[0] = 8'h55;
        do_read(4'd10, 5'd1, d, -1, 0);

        // Stray read command pulsed mid write burst must be ignored.
        d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        do_write(4'd0, 5'd4, d, 2);
        do_read(4'd0, 5'd4, d, -1, 0);

        // Write data offered while idle must not reach the array.
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'hFF;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        chk("idle_wr_busy", {31'd0, busy}, 0);
        chk("idle_wr_ready", {31'd0, wr_ready}, 0);
        d = '0; d[0] = 8'h11;
        do_read(4'd0, 5'd1, d, -1, 0);
        d = '0; d[0] = 8'h55;
        do_read(4'd7, 5'd1, d, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
